if_req_ctrl: RTL and testbench

Instruction-fetch request controller that sits directly upstream of the AXI bridge's inst_sram port. It generates sequential and redirected PCs and drives the SRAM-like request/addr_ok/data_ok handshake with at most one request outstanding. Returned instructions are buffered and handed to the decode stage with a valid/allowin handshake. A redirect (exception flush or taken branch) squashes any in-flight fetch, and its returning data is discarded.

---
 rtl/if_req_ctrl.sv | 155 +++++++++++++++
 tb/tb_if_req_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_req_ctrl.sv
// rtl/if_req_ctrl.sv - instruction-fetch request controller for an SRAM-like inst port
//
// Purpose:
//   Generates sequential and redirected fetch PCs and drives the inst_sram
//   req/addr_ok/data_ok handshake with at most one request outstanding.
//   It buffers one returned instruction for decode (fs_valid/ds_allowin).
//   A redirect squashes the in-flight fetch, and the data it returns is dropped.
//
// Ports:
//   aclk, aresetn             clock, asynchronous active-low reset
//   flush, flush_target       exception/ertn redirect (highest priority)
//   br_taken, br_target       taken-branch redirect from decode
//   ds_allowin                decode accepts the buffered instruction
//   inst_sram_*               SRAM-like request/response port (read only)
//   fs_valid, fs_pc, fs_inst  buffered instruction handed to decode

module if_req_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        cancel_q, cancel_d;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] fs_inst_q, fs_inst_d;

  logic        redir;
  logic [31:0] redir_target;

  assign redir        = flush | br_taken;
  assign redir_target = flush ? flush_target : br_target;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cancel_d   = cancel_q;
    fs_valid_d = fs_valid_q;
    fs_pc_d    = fs_pc_q;
    fs_inst_d  = fs_inst_q;

    case (state_q)
      S_REQ: begin
        if (redir) begin
          fetch_pc_d = redir_target;
          // The bridge still latches the old address on a same-cycle
          // addr_ok, so its response must be discarded.
          if (inst_sram_addr_ok) begin
            cancel_d = 1'b1;
            state_d  = S_WAIT;
          end
        end else if (inst_sram_addr_ok) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (redir) begin
            fetch_pc_d = redir_target;
            cancel_d   = 1'b0;
            state_d    = S_REQ;
          end else if (cancel_q) begin
            cancel_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            fs_inst_d  = inst_sram_rdata;
            fs_pc_d    = fetch_pc_q;
            fs_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end else if (redir) begin
          cancel_d   = 1'b1;
          fetch_pc_d = redir_target;
        end
      end

      S_HOLD: begin
        // data_ok cannot legally arrive here and is ignored.
        if (redir) begin
          fs_valid_d = 1'b0;
          fetch_pc_d = redir_target;
          state_d    = S_REQ;
        end else if (ds_allowin) begin
          fs_valid_d = 1'b0;
          fetch_pc_d = fs_pc_q + PC_STEP;
          state_d    = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      cancel_q   <= 1'b0;
      fs_valid_q <= 1'b0;
      fs_pc_q    <= 32'h0;
      fs_inst_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cancel_q   <= cancel_d;
      fs_valid_q <= fs_valid_d;
      fs_pc_q    <= fs_pc_d;
      fs_inst_q  <= fs_inst_d;
    end
  end

  // Gated by aresetn so the request drops the instant reset is asserted,
  // while the state register itself resets into S_REQ.
  assign inst_sram_req   = aresetn & (state_q == S_REQ);
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign fs_valid = fs_valid_q;
  assign fs_pc    = fs_pc_q;
  assign fs_inst  = fs_inst_q;

endmodule

// File: tb/tb_if_req_ctrl.sv
// tb/tb_if_req_ctrl.sv - directed scoreboard bench for if_req_ctrl

module tb_if_req_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        flush;
  logic [31:0] flush_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  if_req_ctrl dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .flush             (flush),
    .flush_target      (flush_target),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .ds_allowin        (ds_allowin),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .fs_valid          (fs_valid),
    .fs_pc             (fs_pc),
    .fs_inst           (fs_inst)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compare the buffered instruction against the oldest expected entry.
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'h0, fs_valid}, 32'h1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h0, 32'h1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_pc"}, fs_pc, e.pc);
      chk({tag, "_inst"}, fs_inst, e.inst);
    end
  endtask

  // One complete fetch: req at exp_addr, addr_ok, lat idle cycles, data_ok.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                          input logic [31:0] inst, input int lat, input logic allow);
    exp_t e;
    chk({tag, "_req"}, {31'h0, inst_sram_req}, 32'h1);
    chk({tag, "_addr"}, inst_sram_addr, exp_addr);
    inst_sram_addr_ok = 1'b1;
    cyc();
    inst_sram_addr_ok = 1'b0;
    chk({tag, "_req_wait"}, {31'h0, inst_sram_req}, 32'h0);
    repeat (lat) cyc();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = inst;
    ds_allowin        = allow;
    e.pc   = exp_addr;
    e.inst = inst;
    exp_q.push_back(e);
    cyc();
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    check_out(tag);
    if (allow) begin
      cyc();
      ds_allowin = 1'b0;
      chk({tag, "_drop"}, {31'h0, fs_valid}, 32'h0);
    end
  endtask

  initial begin
    aresetn           = 1'b0;
    flush             = 1'b0;
    flush_target      = 32'h0;
    br_taken          = 1'b0;
    br_target         = 32'h0;
    ds_allowin        = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    repeat (3) cyc();
    aresetn = 1'b1;
    #1;

    chk("rst_req", {31'h0, inst_sram_req}, 32'h1);
    chk("rst_addr", inst_sram_addr, 32'h1c000000);
    chk("rst_valid", {31'h0, fs_valid}, 32'h0);
    chk("rst_pc", fs_pc, 32'h0);
    chk("rst_inst", fs_inst, 32'h0);
    chk("const_wr", {31'h0, inst_sram_wr}, 32'h0);
    chk("const_size", {30'h0, inst_sram_size}, 32'h2);
    chk("const_wstrb", {28'h0, inst_sram_wstrb}, 32'h0);
    chk("const_wdata", inst_sram_wdata, 32'h0);

    // 1: first fetch, addr_ok one cycle after req, data_ok two cycles later.
    cyc();
    do_fetch("t1", 32'h1c000000, 32'h02800c0c, 1, 1'b1);
    chk("t1_next_req", {31'h0, inst_sram_req}, 32'h1);
    chk("t1_next_addr", inst_sram_addr, 32'h1c000004);

    // 2: decode stalls for five cycles while the buffer holds.
    do_fetch("t2", 32'h1c000004, 32'h00150004, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_hold_valid", {31'h0, fs_valid}, 32'h1);
      chk("t2_hold_pc", fs_pc, 32'h1c000004);
      chk("t2_hold_inst", fs_inst, 32'h00150004);
      chk("t2_hold_req", {31'h0, inst_sram_req}, 32'h0);
    end
    ds_allowin = 1'b1;
    cyc();
    ds_allowin = 1'b0;
    chk("t2_valid_fall", {31'h0, fs_valid}, 32'h0);
    chk("t2_next_addr", inst_sram_addr, 32'h1c000008);

    // 3: branch while waiting for data; the stale response is dropped.
    inst_sram_addr_ok = 1'b1;
    cyc();
    inst_sram_addr_ok = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h1c000100;
    cyc();
    br_taken = 1'b0;
    chk("t3_req_wait", {31'h0, inst_sram_req}, 32'h0);
    cyc();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'hdeadbeef;
    cyc();
    inst_sram_data_ok = 1'b0;
    chk("t3_valid", {31'h0, fs_valid}, 32'h0);
    do_fetch("t3", 32'h1c000100, 32'h03400000, 0, 1'b0);

    // 4: flush and branch together in HOLD with allowin; flush wins.
    flush        = 1'b1;
    flush_target = 32'h1c008000;
    br_taken     = 1'b1;
    br_target    = 32'h1c000100;
    ds_allowin   = 1'b1;
    cyc();
    flush      = 1'b0;
    br_taken   = 1'b0;
    ds_allowin = 1'b0;
    chk("t4_valid", {31'h0, fs_valid}, 32'h0);
    chk("t4_req", {31'h0, inst_sram_req}, 32'h1);
    chk("t4_addr", inst_sram_addr, 32'h1c008000);

    // 5: redirect in the same cycle as addr_ok.
    inst_sram_addr_ok = 1'b1;
    br_taken          = 1'b1;
    br_target         = 32'h1c000200;
    cyc();
    inst_sram_addr_ok = 1'b0;
    br_taken          = 1'b0;
    chk("t5_req_wait", {31'h0, inst_sram_req}, 32'h0);
    cyc();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h0badc0de;
    cyc();
    inst_sram_data_ok = 1'b0;
    chk("t5_valid", {31'h0, fs_valid}, 32'h0);
    do_fetch("t5", 32'h1c000200, 32'h28c00001, 1, 1'b0);

    // 5b: data_ok and branch in the same WAIT cycle are treated as cancelled.
    ds_allowin = 1'b1;
    cyc();
    ds_allowin = 1'b0;
    chk("t5b_addr", inst_sram_addr, 32'h1c000204);
    inst_sram_addr_ok = 1'b1;
    cyc();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h11111111;
    br_taken          = 1'b1;
    br_target         = 32'h1c000300;
    cyc();
    inst_sram_data_ok = 1'b0;
    br_taken          = 1'b0;
    chk("t5b_valid", {31'h0, fs_valid}, 32'h0);
    chk("t5b_req", {31'h0, inst_sram_req}, 32'h1);
    chk("t5b_addr_tgt", inst_sram_addr, 32'h1c000300);

    // Stray data_ok in REQ is ignored; then fetch at the top of memory and wrap.
    flush        = 1'b1;
    flush_target = 32'hfffffffc;
    cyc();
    flush = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h22222222;
    cyc();
    inst_sram_data_ok = 1'b0;
    chk("stray_valid", {31'h0, fs_valid}, 32'h0);
    chk("stray_req", {31'h0, inst_sram_req}, 32'h1);
    do_fetch("wrap", 32'hfffffffc, 32'h4c000020, 0, 1'b1);
    chk("wrap_addr", inst_sram_addr, 32'h00000000);

    // 6: asynchronous reset while in WAIT.
    inst_sram_addr_ok = 1'b1;
    cyc();
    inst_sram_addr_ok = 1'b0;
    chk("t6_req_wait", {31'h0, inst_sram_req}, 32'h0);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_rst_req", {31'h0, inst_sram_req}, 32'h0);
    chk("t6_rst_valid", {31'h0, fs_valid}, 32'h0);
    chk("t6_rst_pc", fs_pc, 32'h0);
    chk("t6_rst_addr", inst_sram_addr, 32'h1c000000);
    cyc();
    aresetn = 1'b1;
    #1;
    do_fetch("t6", 32'h1c000000, 32'h02800c0c, 1, 1'b1);

    chk("sb_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
